// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU-side memory/IO responder.
//   - 128 KB byte RAM at 0x00000-0x1FFFF (1-cycle write, registered read data)
//   - IO page at 0x30000-0x3FFFF: UART RX/TX byte FIFOs, program-finish flag,
//     and a free-running 32-bit cycle counter with a byte-wise snapshot.
//   - 0x20000-0x2FFFF is unmapped: reads return 0x00, writes are dropped.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   mem_a, mem_wr, mem_dout   CPU address / write strobe / write data
//   mem_din                   registered read data to the CPU
//   rdy_out                   low stalls the CPU (RX empty on read, TX full on push)
//   rx_data/rx_valid/rx_ready byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready byte stream to the UART transmitter
//   program_finish            sticky flag set by a write to 0x30004

// Circular byte FIFO; the parent guarantees push only when not full and pop
// only when not empty.
module mem_io_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]            store_r [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;

    assign head  = store_r[rd_ptr_r];
    assign count = count_r;

    // Entry storage; cleared on reset so the head never shows stale bytes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= 8'h00;
            end
        end else if (push) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_finish
);
    localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL  = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [FIFO_DEPTH_LOG2:0] FIFO_EMPTY = {(FIFO_DEPTH_LOG2+1){1'b0}};

    logic [7:0] ram_r [0:(1<<RAM_ADDR_WIDTH)-1];

    logic                     is_io_s;
    logic                     is_ram_s;
    logic [15:0]              io_off_s;
    logic                     unused_addr_s;
    logic [FIFO_DEPTH_LOG2:0] rx_count_s;
    logic [FIFO_DEPTH_LOG2:0] tx_count_s;
    logic [7:0]               rx_head_s;
    logic                     rx_push_s;
    logic                     rx_pop_s;
    logic                     tx_push_s;
    logic                     tx_pop_s;
    logic [7:0]               tx_push_data_s;
    logic                     finish_set_s;
    logic                     stall_s;
    logic [31:0]              counter_r;
    logic [31:0]              snapshot_r;

    assign is_io_s       = (mem_a[17:16] == 2'b11);
    assign is_ram_s      = (mem_a[17] == 1'b0);
    assign io_off_s      = mem_a[15:0];
    assign unused_addr_s = ^mem_a[31:18];

    assign rx_ready  = (rx_count_s != FIFO_FULL);
    assign rx_push_s = rx_valid && rx_ready;
    assign tx_valid  = (tx_count_s != FIFO_EMPTY);
    assign tx_pop_s  = tx_valid && tx_ready;
    // Reset overrides any pending stall so the CPU is never frozen in reset.
    assign rdy_out   = rst_in | ~stall_s;

    mem_io_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (rx_push_s),
        .push_data (rx_data),
        .pop       (rx_pop_s),
        .head      (rx_head_s),
        .count     (rx_count_s)
    );

    mem_io_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (tx_push_s),
        .push_data (tx_push_data_s),
        .pop       (tx_pop_s),
        .head      (tx_data),
        .count     (tx_count_s)
    );

    // IO side effects and stall decision. Fullness/emptiness use the
    // registered counts, so a same-cycle pop never releases a stalled push.
    always_comb begin
        rx_pop_s       = 1'b0;
        tx_push_s      = 1'b0;
        tx_push_data_s = 8'h00;
        finish_set_s   = 1'b0;
        stall_s        = 1'b0;
        if (is_io_s) begin
            if (mem_wr) begin
                case (io_off_s)
                    16'h0000: begin
                        if (mem_dout != 8'h00) begin
                            if (tx_count_s == FIFO_FULL) begin
                                stall_s = 1'b1;
                            end else begin
                                tx_push_s      = 1'b1;
                                tx_push_data_s = mem_dout;
                            end
                        end else begin
                            tx_push_s = 1'b0;
                        end
                    end
                    16'h0004: begin
                        if (tx_count_s == FIFO_FULL) begin
                            stall_s = 1'b1;
                        end else begin
                            tx_push_s      = 1'b1;
                            tx_push_data_s = 8'h00;
                            finish_set_s   = 1'b1;
                        end
                    end
                    default: begin
                        tx_push_s = 1'b0;
                    end
                endcase
            end else begin
                if (io_off_s == 16'h0000) begin
                    if (rx_count_s == FIFO_EMPTY) begin
                        stall_s = 1'b1;
                    end else begin
                        rx_pop_s = 1'b1;
                    end
                end else begin
                    rx_pop_s = 1'b0;
                end
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_out && mem_wr && is_ram_s) begin
            ram_r[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
        end
    end

    // Free-running counter and the snapshot taken on a 0x30004 read, so the
    // upper bytes read later all belong to the same sample.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            counter_r  <= 32'h0000_0000;
            snapshot_r <= 32'h0000_0000;
        end else begin
            counter_r <= counter_r + 32'h0000_0001;
            if (rdy_out && !mem_wr && is_io_s && (io_off_s == 16'h0004)) begin
                snapshot_r <= counter_r;
            end
        end
    end

    // Registered read data; holds on writes and stalled cycles.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (rdy_out && !mem_wr) begin
            if (is_io_s) begin
                case (io_off_s)
                    16'h0000: mem_din <= rx_head_s;
                    16'h0004: mem_din <= counter_r[7:0];
                    16'h0005: mem_din <= snapshot_r[15:8];
                    16'h0006: mem_din <= snapshot_r[23:16];
                    16'h0007: mem_din <= snapshot_r[31:24];
                    default:  mem_din <= 8'h00;
                endcase
            end else if (is_ram_s) begin
                mem_din <= ram_r[mem_a[RAM_ADDR_WIDTH-1:0]];
            end else begin
                mem_din <= 8'h00;
            end
        end
    end

    // Sticky end-of-program flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            program_finish <= 1'b0;
        end else if (finish_set_s) begin
            program_finish <= 1'b1;
        end
    end
endmodule
